// File: rtl/projection_scheduler_if.sv
// rtl/projection_scheduler_if.sv - triangle in / shared divider / projected triangle out bundle
// Ports (signals):
//   in_valid, in_ready, x1..z3             triangle input handshake and vertex coords
//   div_start, div_num, div_den            request to the shared signed divider
//   div_done, div_quot                     divider response
//   out_valid, out_ready, reject, ox*/oy*  projected triangle output handshake
// Modports: slave = projection_scheduler, master = its environment.
interface projection_scheduler_if #(
  parameter int W = 32
);
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] x1, y1, z1, x2, y2, z2, x3, y3, z3;

  logic                div_start;
  logic signed [W-1:0] div_num;
  logic signed [W-1:0] div_den;
  logic                div_done;
  logic signed [W-1:0] div_quot;

  logic                out_valid;
  logic                out_ready;
  logic                reject;
  logic signed [W-1:0] ox1, oy1, ox2, oy2, ox3, oy3;

  modport slave (
    input  in_valid, x1, y1, z1, x2, y2, z2, x3, y3, z3,
    output in_ready,
    output div_start, div_num, div_den,
    input  div_done, div_quot,
    output out_valid, reject, ox1, oy1, ox2, oy2, ox3, oy3,
    input  out_ready
  );

  modport master (
    output in_valid, x1, y1, z1, x2, y2, z2, x3, y3, z3,
    input  in_ready,
    input  div_start, div_num, div_den,
    output div_done, div_quot,
    input  out_valid, reject, ox1, oy1, ox2, oy2, ox3, oy3,
    output out_ready
  );
endinterface

// File: rtl/projection_scheduler.sv
// rtl/projection_scheduler.sv - perspective projection sequencer for one triangle over a shared divider
// Optional feature macro: PROJ_SAT_EN (saturate coord*D_FOCAL to W bits instead of wrapping).
// Ports:
//   clk  in  system clock, rising edge
//   rst  in  synchronous active-high reset
//   bus  projection_scheduler_if.slave: triangle input, divider request/response, result output
module projection_scheduler #(
  parameter int W       = 32,
  parameter int D_FOCAL = 600,
  parameter int Z_MIN   = 1
) (
  input logic                   clk,
  input logic                   rst,
  projection_scheduler_if.slave bus
);
  localparam logic signed [W-1:0] FOCAL = W'(D_FOCAL);
  localparam logic signed [W-1:0] ZMIN  = W'(Z_MIN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          k_q, k_d;
  logic                in_ready_q, in_ready_d;
  logic                div_start_q, div_start_d;
  logic signed [W-1:0] div_num_q, div_num_d;
  logic signed [W-1:0] div_den_q, div_den_d;
  logic                out_valid_q, out_valid_d;
  logic                reject_q, reject_d;
  logic                cull_q, cull_d;
  logic signed [W-1:0] x_q [3], x_d [3];
  logic signed [W-1:0] y_q [3], y_d [3];
  logic signed [W-1:0] z_q [3], z_d [3];
  logic signed [W-1:0] ox_q [3], ox_d [3];
  logic signed [W-1:0] oy_q [3], oy_d [3];

  logic [2:0]          sel_k;
  logic signed [W-1:0] sel_coord;
  logic signed [W-1:0] sel_z;

  function automatic logic signed [W-1:0] scale(input logic signed [W-1:0] c);
`ifdef PROJ_SAT_EN
    logic signed [2*W-1:0] p;
    p = (2*W)'(c) * (2*W)'(FOCAL);
    // Fits in W bits only when the top W+1 bits are all sign copies.
    if (p[2*W-1:W-1] == {(W+1){1'b0}} || p[2*W-1:W-1] == {(W+1){1'b1}})
      return p[W-1:0];
    else if (p[2*W-1])
      return {1'b1, {(W-1){1'b0}}};
    else
      return {1'b0, {(W-1){1'b1}}};
`else
    return c * FOCAL;
`endif
  endfunction

  // Operand select for the op about to be issued: op 0 when leaving CHECK, else the op after k.
  always_comb begin
    sel_k = (state_q == S_CHECK) ? 3'd0 : k_q + 3'd1;
    case (sel_k)
      3'd0:    sel_coord = x_q[0];
      3'd1:    sel_coord = y_q[0];
      3'd2:    sel_coord = x_q[1];
      3'd3:    sel_coord = y_q[1];
      3'd4:    sel_coord = x_q[2];
      default: sel_coord = y_q[2];
    endcase
    case (sel_k[2:1])
      2'd0:    sel_z = z_q[0];
      2'd1:    sel_z = z_q[1];
      default: sel_z = z_q[2];
    endcase
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    in_ready_d  = in_ready_q;
    div_start_d = 1'b0;
    div_num_d   = div_num_q;
    div_den_d   = div_den_q;
    out_valid_d = out_valid_q;
    reject_d    = reject_q;
    cull_d      = cull_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    ox_d        = ox_q;
    oy_d        = oy_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          x_d[0] = bus.x1; y_d[0] = bus.y1; z_d[0] = bus.z1;
          x_d[1] = bus.x2; y_d[1] = bus.y2; z_d[1] = bus.z2;
          x_d[2] = bus.x3; y_d[2] = bus.y3; z_d[2] = bus.z3;
          ox_d       = '{default: '0};
          oy_d       = '{default: '0};
          cull_d     = 1'b0;
          in_ready_d = 1'b0;
          state_d    = S_CHECK;
        end
      end
      S_CHECK: begin
        if (z_q[0] < ZMIN || z_q[1] < ZMIN || z_q[2] < ZMIN) begin
          cull_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          k_d         = 3'd0;
          div_start_d = 1'b1;
          div_num_d   = scale(sel_coord);
          div_den_d   = sel_z;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.div_done) begin
          if (k_q[0]) oy_d[k_q[2:1]] = bus.div_quot;
          else        ox_d[k_q[2:1]] = bus.div_quot;
          if (k_q == 3'd5) begin
            state_d = S_DONE;
          end else begin
            k_d         = k_q + 3'd1;
            div_start_d = 1'b1;
            div_num_d   = scale(sel_coord);
            div_den_d   = sel_z;
            state_d     = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          reject_d    = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end else begin
          // Result is presented one cycle after entering DONE.
          out_valid_d = 1'b1;
          reject_d    = cull_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= 3'd0;
      in_ready_q  <= 1'b1;
      div_start_q <= 1'b0;
      div_num_q   <= '0;
      div_den_q   <= '0;
      out_valid_q <= 1'b0;
      reject_q    <= 1'b0;
      cull_q      <= 1'b0;
      x_q         <= '{default: '0};
      y_q         <= '{default: '0};
      z_q         <= '{default: '0};
      ox_q        <= '{default: '0};
      oy_q        <= '{default: '0};
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      in_ready_q  <= in_ready_d;
      div_start_q <= div_start_d;
      div_num_q   <= div_num_d;
      div_den_q   <= div_den_d;
      out_valid_q <= out_valid_d;
      reject_q    <= reject_d;
      cull_q      <= cull_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.div_start = div_start_q;
  assign bus.div_num   = div_num_q;
  assign bus.div_den   = div_den_q;
  assign bus.out_valid = out_valid_q;
  assign bus.reject    = reject_q;
  assign bus.ox1       = ox_q[0];
  assign bus.oy1       = oy_q[0];
  assign bus.ox2       = ox_q[1];
  assign bus.oy2       = oy_q[1];
  assign bus.ox3       = ox_q[2];
  assign bus.oy3       = oy_q[2];
endmodule
